wbu_csr_master: RTL

- Write-back-stage sequencer and requesting end of the WBU→CSR valid/ready write channel.
- Accepts one retired instruction from LSU per transaction and, for SYSTEM-class instructions, reads the old CSR value and computes the CSR write data.
- Issues the CSR request, waits for the CSR unit's one-cycle write phase, then commits the rd write and next PC to IFU.
- Non-CSR instructions pass straight through to commit.

---
 rtl/wbu_csr_master.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/wbu_csr_master.sv
// Write-back sequencer: accepts one retired instruction and runs the CSR request/write phase for SYSTEM ops.
// It then commits the rd write and the next PC to the IFU.
module wbu_csr_master #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter logic [11:0] MTVEC_ADDR = 12'h305
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_wbu_valid,
  output logic        lsu_wbu_ready,
  input  logic [31:0] lsu_to_wbu_inst,
  input  logic [31:0] lsu_pc,
  input  logic [31:0] lsu_dnpc,
  input  logic [31:0] lsu_rs1_data,
  input  logic [31:0] lsu_result,
  output logic [11:0] csr_addr,
  input  logic [31:0] csr_rdata,
  output logic        wbu_csr_valid,
  input  logic        wbu_csr_ready,
  output logic [31:0] csr_wdata,
  output logic [31:0] lsu_to_csr_inst,
  output logic [31:0] csr_pc,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        wbu_ifu_valid,
  input  logic        wbu_ifu_ready,
  output logic [31:0] next_pc
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CSR_REQ  = 2'd1,
    CSR_WAIT = 2'd2,
    COMMIT   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] dnpc_q, dnpc_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] result_q, result_d;
  logic [31:0] old_csr_q, old_csr_d;

  function automatic logic csr_class_f(input logic [31:0] i);
    logic sys;
    sys = (i[6:0] == 7'b1110011);
    return sys && ((i[14:12] == 3'b000 && (i[31:20] == 12'h000 || i[31:20] == 12'h302)) ||
                   i[14:12] == 3'b001 || i[14:12] == 3'b010);
  endfunction

  logic is_sys_s, is_ecall_s, is_mret_s, is_csrrw_s, is_csrrs_s, rd_we_s;
  logic unused_param_s;

  assign is_sys_s   = (inst_q[6:0] == 7'b1110011);
  assign is_ecall_s = is_sys_s && (inst_q[14:12] == 3'b000) && (inst_q[31:20] == 12'h000);
  assign is_mret_s  = is_sys_s && (inst_q[14:12] == 3'b000) && (inst_q[31:20] == 12'h302);
  assign is_csrrw_s = is_sys_s && (inst_q[14:12] == 3'b001);
  assign is_csrrs_s = is_sys_s && (inst_q[14:12] == 3'b010);
  assign rd_we_s    = !((inst_q[6:0] == 7'b0100011) || (inst_q[6:0] == 7'b1100011) ||
                        is_ecall_s || is_mret_s) && (inst_q[11:7] != 5'd0);
  assign unused_param_s = ^MTVEC_ADDR;

  assign csr_addr        = inst_q[31:20];
  assign lsu_to_csr_inst = inst_q;
  assign csr_pc          = pc_q;
  assign rf_waddr        = inst_q[11:7];
  assign rf_wdata        = (is_csrrw_s || is_csrrs_s) ? old_csr_q : result_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      inst_q    <= 32'h0;
      pc_q      <= 32'h0;
      dnpc_q    <= 32'h0;
      rs1_q     <= 32'h0;
      result_q  <= 32'h0;
      old_csr_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      pc_q      <= pc_d;
      dnpc_q    <= dnpc_d;
      rs1_q     <= rs1_d;
      result_q  <= result_d;
      old_csr_q <= old_csr_d;
    end
  end

  // Old CSR value is captured on the request handshake, before the CSR unit's write phase.
  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    pc_d      = pc_q;
    dnpc_d    = dnpc_q;
    rs1_d     = rs1_q;
    result_d  = result_q;
    old_csr_d = old_csr_q;
    case (state_q)
      IDLE: begin
        if (lsu_wbu_valid) begin
          inst_d   = lsu_to_wbu_inst;
          pc_d     = lsu_pc;
          dnpc_d   = lsu_dnpc;
          rs1_d    = lsu_rs1_data;
          result_d = lsu_result;
          state_d  = csr_class_f(lsu_to_wbu_inst) ? CSR_REQ : COMMIT;
        end
      end
      CSR_REQ: begin
        if (wbu_csr_ready) begin
          old_csr_d = csr_rdata;
          state_d   = CSR_WAIT;
        end
      end
      CSR_WAIT: state_d = COMMIT;
      COMMIT: begin
        if (wbu_ifu_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lsu_wbu_ready = 1'b0;
    wbu_csr_valid = 1'b0;
    wbu_ifu_valid = 1'b0;
    rf_wen        = 1'b0;
    csr_wdata     = 32'h0;
    next_pc       = RESET_PC;
    case (state_q)
      IDLE: lsu_wbu_ready = 1'b1;
      CSR_REQ: begin
        wbu_csr_valid = 1'b1;
        if (is_csrrw_s) begin
          csr_wdata = rs1_q;
        end else if (is_csrrs_s) begin
          csr_wdata = csr_rdata | rs1_q;
        end else if (is_ecall_s) begin
          csr_wdata = pc_q;
        end else begin
          csr_wdata = 32'h0;
        end
      end
      CSR_WAIT: wbu_csr_valid = 1'b0;
      COMMIT: begin
        wbu_ifu_valid = 1'b1;
        if (is_ecall_s) begin
          next_pc = mtvec;
        end else if (is_mret_s) begin
          next_pc = mepc;
        end else begin
          next_pc = dnpc_q;
        end
        rf_wen = wbu_ifu_ready && rd_we_s;
      end
      default: lsu_wbu_ready = 1'b0;
    endcase
  end

endmodule
